// File: rtl/alu_serial_seq.sv
// alu_serial_seq -- bit-serial ALU sequencer.
//
// Accepts a WIDTH-bit operation through a start/ready handshake and walks it
// through an external 1-bit ALU slice one bit per cycle, LSB first. Carry is
// fed forward between bits in a register. SLT gets one extra fix-up cycle that
// turns the overflow-corrected sign of (src1 - src2) into a 0/1 result.
//
// Configuration macro: ALU_SEQ_FLAGS_EN
//   defined   : zero_o / overflow_o are registered alongside result_o
//   undefined : zero_o / overflow_o are tied to 0
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, ready_o        request handshake (accepted when both high)
//   ctrl_i                  operation code (AND/OR/ADD/SUB/SLT/NOR)
//   src1_i, src2_i          operands, sampled on acceptance only
//   done_o                  one-cycle completion pulse
//   result_o                result register, held until the next completion
//   zero_o, overflow_o      result flags
//   slice_*_o               per-bit drive to the external slice
//   slice_result_i/cout_i   combinational slice outputs

module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             slice_a_o,
    output logic             slice_b_o,
    output logic             slice_cin_o,
    output logic             slice_ainv_o,
    output logic             slice_binv_o,
    output logic [1:0]       slice_op_o,
    input  logic             slice_result_i,
    input  logic             slice_cout_i
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, result_r;
    logic [3:0]       ctrl_r;
    logic [CNT_W-1:0] bit_cnt;
    logic             carry_r;
    logic             cin_msb, cout_msb, sum_msb;

    logic             accept, last_bit, supported, first_cin;
    logic [WIDTH-1:0] run_result, slt_result;

    // Slice decode from the latched operation code.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        slice_ainv_o = 1'b0;
        slice_binv_o = 1'b0;
        slice_op_o   = 2'd0;
        first_cin    = 1'b0;
        supported    = 1'b1;
        case (ctrl_r)
            CTRL_AND: ;
            CTRL_OR:  slice_op_o = 2'd1;
            CTRL_ADD: slice_op_o = 2'd2;
            CTRL_SUB, CTRL_SLT: begin
                slice_binv_o = 1'b1;
                slice_op_o   = 2'd2;
                first_cin    = 1'b1;   // two's-complement +1
            end
            CTRL_NOR: begin
                slice_ainv_o = 1'b1;
                slice_binv_o = 1'b1;
            end
            default:  supported = 1'b0;
        endcase
    end

    assign slice_a_o   = a_sr[0];
    assign slice_b_o   = b_sr[0];
    // Bit 0 of an arithmetic op takes its fixed carry-in; everything else,
    // including logical ops where it does not matter, comes from carry_r.
    assign slice_cin_o = (bit_cnt == '0 && slice_op_o == 2'd2) ? first_cin : carry_r;

    assign ready_o    = (state == IDLE) || (state == DONE);
    assign done_o     = (state == DONE);
    assign result_o   = result_r;
    assign accept     = start_i && ready_o;
    assign last_bit   = (bit_cnt == LAST_BIT);

    // Next value of the assembly register: new bit enters at the MSB end so
    // that after WIDTH shifts bit 0 sits at the LSB.
    assign run_result = {(supported ? slice_result_i : 1'b0), res_sr[WIDTH-1:1]};
    // Signed less-than = sign of the difference corrected by overflow.
    assign slt_result = {{(WIDTH-1){1'b0}}, sum_msb ^ (cin_msb ^ cout_msb)};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = RUN;
            RUN:  if (last_bit) state_nxt = (ctrl_r == CTRL_SLT) ? FIX : DONE;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = start_i ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic zero_r, ovf_r, is_addsub;
    assign is_addsub  = (ctrl_r == CTRL_ADD) || (ctrl_r == CTRL_SUB);
    assign zero_o     = zero_r;
    assign overflow_o = ovf_r;
`else
    assign zero_o     = 1'b0;
    assign overflow_o = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            result_r <= '0;
            ctrl_r   <= CTRL_AND;
            bit_cnt  <= '0;
            carry_r  <= 1'b0;
            cin_msb  <= 1'b0;
            cout_msb <= 1'b0;
            sum_msb  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sr    <= src1_i;
                b_sr    <= src2_i;
                ctrl_r  <= ctrl_i;
                bit_cnt <= '0;
            end
            if (state == RUN) begin
                res_sr  <= run_result;
                carry_r <= slice_cout_i;
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (last_bit) begin
                    cin_msb  <= slice_cin_o;
                    cout_msb <= slice_cout_i;
                    sum_msb  <= slice_result_i;
                    if (ctrl_r != CTRL_SLT) begin
                        result_r <= run_result;
`ifdef ALU_SEQ_FLAGS_EN
                        zero_r   <= (run_result == '0);
                        ovf_r    <= is_addsub & (slice_cin_o ^ slice_cout_i);
`endif
                    end
                end
            end
            if (state == FIX) begin
                result_r <= slt_result;
`ifdef ALU_SEQ_FLAGS_EN
                zero_r   <= (slt_result == '0);
                ovf_r    <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Testbench for alu_serial_seq (WIDTH=32) with a behavioural 1-bit ALU slice.
// Latency is counted in rising edges after the acceptance edge: done_o is
// visible after edge WIDTH (non-SLT) or WIDTH+1 (SLT).

module tb_alu_serial_seq;

    localparam int W = 32;
`ifdef ALU_SEQ_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   ctrl = 4'd0;
    logic [W-1:0] src1 = '0, src2 = '0;
    logic         ready, done, zero, overflow;
    logic [W-1:0] result;
    logic         s_a, s_b, s_cin, s_ainv, s_binv, s_res, s_cout;
    logic [1:0]   s_op;
    logic         ea, eb;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
        .src1_i(src1), .src2_i(src2), .ready_o(ready), .done_o(done),
        .result_o(result), .zero_o(zero), .overflow_o(overflow),
        .slice_a_o(s_a), .slice_b_o(s_b), .slice_cin_o(s_cin),
        .slice_ainv_o(s_ainv), .slice_binv_o(s_binv), .slice_op_o(s_op),
        .slice_result_i(s_res), .slice_cout_i(s_cout)
    );

    // Behavioural 1-bit ALU slice.
    assign ea     = s_a ^ s_ainv;
    assign eb     = s_b ^ s_binv;
    assign s_cout = (ea & eb) | (ea & s_cin) | (eb & s_cin);
    assign s_res  = (s_op == 2'd0) ? (ea & eb) :
                    (s_op == 2'd1) ? (ea | eb) : (ea ^ eb ^ s_cin);

    typedef struct {
        string        name;
        logic [3:0]   ctrl;
        logic [W-1:0] a, b, res;
        logic         zero, ovf;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for done_o after an acceptance edge; returns edges counted.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 100);
    endtask

    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        int n;
        @(negedge clk);
        start = 1'b1; ctrl = c; src1 = a; src2 = b;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        src1 = 32'hA5A5_5A5A; src2 = 32'h1234_4321;
        wait_done(lat);
    endtask

    initial begin
        int lat, t1, t2, n;
        bit seen;

        vecs.push_back('{"add_5_3",        4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, W});
        vecs.push_back('{"add_ovf",        4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, W});
        vecs.push_back('{"add_wrap",       4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, W});
        vecs.push_back('{"sub_min_1",      4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, W});
        vecs.push_back('{"sub_7_7",        4'b0110, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, W});
        vecs.push_back('{"sub_3_5",        4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, W});
        vecs.push_back('{"slt_m2_1",       4'b0111, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, W+1});
        vecs.push_back('{"slt_max_min",    4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, W+1});
        vecs.push_back('{"slt_min_max",    4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, W+1});
        vecs.push_back('{"slt_eq",         4'b0111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, W+1});
        vecs.push_back('{"and",            4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, W});
        vecs.push_back('{"or",             4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1'b0, W});
        vecs.push_back('{"nor",            4'b1100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, 1'b0, 1'b0, W});
        vecs.push_back('{"unsupported",    4'b1111, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0000_0000, 1'b1, 1'b0, W});

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  ready,  1);
        check("rst_done",   done,   0);
        check("rst_result", result, 0);
        check("rst_zero",   zero,   0);
        check("rst_ovf",    overflow, 0);
        check("rst_slice",  {s_a, s_b, s_cin, s_ainv, s_binv, s_op}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven operations.
        foreach (vecs[i]) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat);
            check({vecs[i].name, "_lat"},    lat,      vecs[i].lat);
            check({vecs[i].name, "_result"}, result,   vecs[i].res);
            check({vecs[i].name, "_zero"},   zero,     FLAGS & vecs[i].zero);
            check({vecs[i].name, "_ovf"},    overflow, FLAGS & vecs[i].ovf);
        end

        // Result register holds through IDLE.
        repeat (3) @(posedge clk);
        #1;
        check("hold_idle_ready",  ready,  1);
        check("hold_idle_result", result, 32'h0000_0000);

        // start_i held high: accepted only in DONE cycles, operand churn ignored.
        @(negedge clk);
        start = 1'b1; ctrl = 4'b0010; src1 = 32'd1; src2 = 32'd2;
        @(posedge clk); #1;
        check("held_busy_ready", ready, 0);
        ctrl = 4'b0110; src1 = 32'hDEAD; src2 = 32'hBEEF;
        wait_done(n);
        t1 = cyc;
        check("held_op1_lat",    n,      W);
        check("held_op1_result", result, 32'd3);
        ctrl = 4'b0010; src1 = 32'd10; src2 = 32'd20;
        @(posedge clk); #1;
        ctrl = 4'b0000; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
        wait_done(n);
        t2 = cyc;
        check("held_spacing",    t2 - t1, W + 1);
        check("held_op2_result", result,  32'd30);
        start = 1'b0;

        // Reset in the middle of an ADD.
        @(negedge clk);
        start = 1'b1; ctrl = 4'b0010; src1 = 32'h1234_5678; src2 = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready",  ready,  1);
        check("midrst_done",   done,   0);
        check("midrst_result", result, 0);
        check("midrst_flags",  {zero, overflow}, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("midrst_no_done", seen, 0);
        run_op(4'b0010, 32'd1, 32'd1, lat);
        check("post_rst_lat",    lat,    W);
        check("post_rst_result", result, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial ALU sequencer: accepts a WIDTH-bit operation through a start/ready handshake and computes it one bit per cycle on the team's external 1-bit ALU slice. The block drives the slice inputs, feeds carry forward between bits and assembles the result LSB first. It also performs the SLT fix-up pass and reports completion.

## Interface
- WIDTH, 32, operand/result width; legal range 2..64
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  request; accepted when start_i && ready_o at a rising edge
- ctrl_i  in  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; others unsupported
- src1_i, src2_i  in  WIDTH  operands, sampled only on acceptance
- ready_o  out  1  high in IDLE and DONE
- done_o  out  1  one-cycle pulse; result_o valid from this cycle until next acceptance
- result_o  out  WIDTH  result register
- zero_o, overflow_o  out  1  flags (see Configuration)
- slice_a_o, slice_b_o, slice_cin_o, slice_ainv_o, slice_binv_o  out  1  current-bit drive to slice
- slice_op_o  out  2  slice op: 0 AND, 1 OR, 2 ADD
- slice_result_i, slice_cout_i  in  1  slice outputs, combinational from slice_*_o

## Operation
- States: IDLE, RUN, FIX, DONE. Reset -> IDLE; all outputs 0 except ready_o=1.
- Acceptance (IDLE or DONE): latch src1/src2 into shift registers, latch ctrl, bit counter=0, go RUN.
- Slice decode: AND ainv0 binv0 op0; OR op0→1; ADD op2 cin0; SUB/SLT binv1 op2, bit-0 cin=1; NOR ainv1 binv1 op0; unsupported: op0, captured bit forced 0.
- RUN, each edge: shift slice_result_i (or forced 0) into result MSB end (LSB-first assembly); carry reg <= slice_cout_i; shift operands right; counter++. During the bit WIDTH-1 cycle record cin_msb=slice_cin_o, cout_msb=slice_cout_i, sum_msb=slice_result_i.
- slice_cin_o = 1 for bit 0 of SUB/SLT, else carry reg (0 for bit 0 of ADD); irrelevant for logical ops but still driven from carry reg (reset 0).
- After bit WIDTH-1: SLT -> FIX, else -> DONE.
- FIX: result <= {0…0, sum_msb ^ (cin_msb ^ cout_msb)}; -> DONE.
- DONE: done_o=1 for that cycle; without start_i -> IDLE; with start_i -> new acceptance, RUN.
- start_i while RUN/FIX: ignored, no queuing; src/ctrl changes during RUN have no effect.
- rst_i mid-operation: immediate IDLE, result_o/flags cleared, no done_o.

## Timing
- Acceptance at edge E0; bits processed at edges E1..E_WIDTH; done_o high cycle after E_WIDTH (non-SLT) -> latency WIDTH+1 cycles; SLT WIDTH+2.
- Back-to-back: start in DONE cycle -> next done exactly WIDTH+1 (or +2) cycles later; throughput one op per WIDTH+1 cycles.
- slice_*_o are registered state or decode of registered state; no combinational path from start_i/src*_i to slice outputs.
- result_o, zero_o, overflow_o change only at the DONE-entry edge and at reset; stable otherwise, including through IDLE.

## Configuration
- ALU_SEQ_FLAGS_EN defined: zero_o = (final result == 0), overflow_o = cin_msb ^ cout_msb for ADD/SUB, 0 for other ops; both updated with result_o on DONE entry.
- Undefined: zero_o, overflow_o tied 0; no flag logic or MSB carry capture beyond what SLT needs.

## Test plan
- Reset then ADD 0x0000_0005 + 0x0000_0003 -> done_o at cycle 33 after acceptance, result_o=0x0000_0008, zero_o=0, overflow_o=0.
- SUB 0x8000_0000 - 0x0000_0001 -> result_o=0x7FFF_FFFF, overflow_o=1 (flags build); SUB 7-7 -> 0, zero_o=1.
- SLT 0xFFFF_FFFE (-2) vs 0x0000_0001 -> 1 at cycle 34; SLT 0x7FFF_FFFF vs 0x8000_0000 -> 0 (overflow-corrected).
- AND/OR/NOR on 0xF0F0_1234, 0x0FF0_FF00 -> 0x00F0_1200 / 0xFFF0_FF34 / 0x000F_00CB; unsupported ctrl 1111 -> 0x0000_0000, done same latency.
- start_i held high continuously with changing operands -> ops accepted only in DONE cycles, spacing 33 cycles, mid-RUN operand changes ignored.
- rst_i asserted at bit 10 of ADD -> next cycle IDLE, ready_o=1, result_o=0, no done_o; fresh ADD 1+1 then returns 2.
